// File: rtl/eth_domain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eth_domain_ctrl
// Purpose  : Power/isolation sequencer for the Ethernet island. Power-up runs
//            clock enable -> reset release -> AXI de-isolation; power-down runs
//            AXI isolation -> reset assertion -> clock gating. A sticky error
//            flags an island that never acknowledges an isolation change.
// Ports    : clk_i          host clock
//            rst_ni         asynchronous active-low reset
//            en_i           level request, 1 = island on
//            err_clr_i      single-cycle pulse clearing err_o
//            axi_isolated_i isolation acknowledge (asynchronous, synchronized)
//            clk_en_o       island clock-gate enable
//            domain_rst_no  island reset, active-low
//            axi_isolate_o  AXI isolate request
//            busy_o         high while sequencing (not OFF, not ON)
//            on_o           high only in ON
//            err_o          sticky acknowledge-timeout error
//            state_o        FSM state encoding
// Options  : ETH_DOMAIN_CTRL_TIMEOUT_EN compiles in the acknowledge timeout;
//            without it DEISO/ISO wait forever and err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module eth_domain_ctrl #(
    parameter int ClkSettleCycles = 8,
    parameter int RstHoldCycles   = 16,
    parameter int TimeoutCycles   = 1024,
    parameter int SyncStages      = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       err_clr_i,
    input  logic       axi_isolated_i,
    output logic       clk_en_o,
    output logic       domain_rst_no,
    output logic       axi_isolate_o,
    output logic       busy_o,
    output logic       on_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    if (ClkSettleCycles < 1 || RstHoldCycles < 1 || TimeoutCycles < 1 || SyncStages < 2) begin : g_param_check
        $error("eth_domain_ctrl: parameter out of range");
    end

    localparam int c_max_ab = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
`ifdef ETH_DOMAIN_CTRL_TIMEOUT_EN
    localparam int c_cnt_max = (TimeoutCycles > c_max_ab) ? TimeoutCycles : c_max_ab;
`else
    localparam int c_cnt_max = c_max_ab;
`endif
    localparam int c_cnt_w = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_ld_settle  = c_cnt_w'(ClkSettleCycles);
    localparam logic [c_cnt_w-1:0] c_ld_hold    = c_cnt_w'(RstHoldCycles);
`ifdef ETH_DOMAIN_CTRL_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_ld_timeout = c_cnt_w'(TimeoutCycles);
`else
    localparam logic [c_cnt_w-1:0] c_ld_timeout = '0;
`endif

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_CLK_ON     = 3'd1,
        ST_RST_REL    = 3'd2,
        ST_DEISO      = 3'd3,
        ST_ON         = 3'd4,
        ST_ISO        = 3'd5,
        ST_RST_ASSERT = 3'd6,
        ST_CLK_OFF    = 3'd7
    } state_t;

    // Output vector order: {clk_en, rst_n, isolate, busy, on}
    function automatic logic [4:0] f_out(input state_t s);
        logic [4:0] v;
        v = 5'b00100;
        case (s)
            ST_OFF:        v = 5'b00100;
            ST_CLK_ON:     v = 5'b10110;
            ST_RST_REL:    v = 5'b11110;
            ST_DEISO:      v = 5'b11010;
            ST_ON:         v = 5'b11001;
            ST_ISO:        v = 5'b11110;
            ST_RST_ASSERT: v = 5'b10110;
            ST_CLK_OFF:    v = 5'b00110;
            default:       v = 5'b00100;
        endcase
        return v;
    endfunction

    state_t               r_state;
    logic [4:0]           r_out;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [SyncStages-1:0] r_sync;
    logic                 w_ack;
    logic                 w_cnt_last;
    logic                 w_timeout;

    // Acknowledge synchronizer; resets to "isolated" so OFF looks consistent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], axi_isolated_i};
        end
    end
    assign w_ack = r_sync[SyncStages-1];

    // A timed state loaded with N exits on the edge where the count would
    // hit zero, so it occupies exactly N cycles.
    assign w_cnt_last = (r_cnt <= c_cnt_w'(1));

`ifdef ETH_DOMAIN_CTRL_TIMEOUT_EN
    assign w_timeout = w_cnt_last;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_OFF;
            r_out   <= f_out(ST_OFF);
            r_cnt   <= '0;
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            unique case (r_state)
                ST_OFF: begin
                    if (en_i) begin
                        r_state <= ST_CLK_ON;
                        r_out   <= f_out(ST_CLK_ON);
                        r_cnt   <= c_ld_settle;
                    end
                end
                ST_CLK_ON: begin
                    if (w_cnt_last) begin
                        r_state <= ST_RST_REL;
                        r_out   <= f_out(ST_RST_REL);
                        r_cnt   <= c_ld_hold;
                    end
                end
                ST_RST_REL: begin
                    if (w_cnt_last) begin
                        r_state <= ST_DEISO;
                        r_out   <= f_out(ST_DEISO);
                        r_cnt   <= c_ld_timeout;
                    end
                end
                ST_DEISO: begin
                    if (!w_ack) begin
                        r_state <= ST_ON;
                        r_out   <= f_out(ST_ON);
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        // Island never de-isolated: force a full shutdown.
                        r_state <= ST_ISO;
                        r_out   <= f_out(ST_ISO);
                        r_cnt   <= c_ld_timeout;
                    end
                end
                ST_ON: begin
                    if (!en_i) begin
                        r_state <= ST_ISO;
                        r_out   <= f_out(ST_ISO);
                        r_cnt   <= c_ld_timeout;
                    end
                end
                ST_ISO: begin
                    // Acknowledge or timeout both lead to reset; a hung
                    // island is reset regardless.
                    if (w_ack || w_timeout) begin
                        r_state <= ST_RST_ASSERT;
                        r_out   <= f_out(ST_RST_ASSERT);
                        r_cnt   <= c_ld_hold;
                    end
                end
                ST_RST_ASSERT: begin
                    // Runs the count fully down to zero: the entry cycle plus
                    // RstHoldCycles clocked cycles keep reset asserted with
                    // the clock running before the gate closes.
                    if (r_cnt == '0) begin
                        r_state <= ST_CLK_OFF;
                        r_out   <= f_out(ST_CLK_OFF);
                        r_cnt   <= '0;
                    end
                end
                ST_CLK_OFF: begin
                    r_state <= ST_OFF;
                    r_out   <= f_out(ST_OFF);
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_OFF;
                    r_out   <= f_out(ST_OFF);
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef ETH_DOMAIN_CTRL_TIMEOUT_EN
    logic r_err;
    logic w_err_set;

    assign w_err_set = w_timeout &&
                       (((r_state == ST_DEISO) && w_ack) ||
                        ((r_state == ST_ISO) && !w_ack));

    // Set has priority over a coincident clear so no timeout is lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr_i) begin
            r_err <= 1'b0;
        end
    end
    assign err_o = r_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr_i;
    assign err_o = 1'b0;
`endif

    assign {clk_en_o, domain_rst_no, axi_isolate_o, busy_o, on_o} = r_out;
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_eth_domain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_domain_ctrl
// Purpose  : Directed bench for eth_domain_ctrl with an island model that
//            acknowledges isolate changes a few cycles late. Output edges are
//            predicted into a queue and matched as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_domain_ctrl;

    localparam int SETTLE = 8;
    localparam int HOLD   = 16;
    localparam int TMO    = 1024;
    localparam int SYNC   = 3;

    // Event codes: signal*2 + new value
    localparam int EV_CLK_DN = 0, EV_CLK_UP = 1;
    localparam int EV_RST_DN = 2, EV_RST_UP = 3;
    localparam int EV_ISO_DN = 4, EV_ISO_UP = 5;
    localparam int EV_ON_DN  = 6, EV_ON_UP  = 7;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic       axi_isolated_i = 1'b1;
    logic       clk_en_o, domain_rst_no, axi_isolate_o, busy_o, on_o, err_o;
    logic [2:0] state_o;

    eth_domain_ctrl #(
        .ClkSettleCycles(SETTLE),
        .RstHoldCycles  (HOLD),
        .TimeoutCycles  (TMO),
        .SyncStages     (SYNC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .en_i          (en_i),
        .err_clr_i     (err_clr_i),
        .axi_isolated_i(axi_isolated_i),
        .clk_en_o      (clk_en_o),
        .domain_rst_no (domain_rst_no),
        .axi_isolate_o (axi_isolate_o),
        .busy_o        (busy_o),
        .on_o          (on_o),
        .err_o         (err_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int code; int cyc; } ev_t;
    ev_t sb[$];

    bit sb_auto = 1'b1;
    bit mon_en  = 1'b1;
    bit hang_low = 1'b0;
    bit hang_high = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void push_ev(input int code, input int c);
        ev_t e;
        e.code = code;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    task automatic ev_check(input int code);
        ev_t e;
        chk("sb_event_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("ev_code@%0d", cyc), 32'(code), 32'(e.code));
            chk($sformatf("ev_cycle_code%0d", code), 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Island model: acknowledge follows the isolate request a few cycles late.
    // Ack edges predict the DUT reaction SYNC+1 cycles later.
    logic [3:0] iso_hist = 4'hF;
    always @(negedge clk) begin
        logic ack_new;
        ack_new = hang_low ? 1'b0 : (hang_high ? 1'b1 : iso_hist[2]);
        iso_hist <= {iso_hist[2:0], axi_isolate_o};
        if (sb_auto && (ack_new !== axi_isolated_i)) begin
            if (!ack_new) begin
                push_ev(EV_ON_UP, cyc + SYNC + 1);
                if (!en_i) begin
                    push_ev(EV_ISO_UP, cyc + SYNC + 2);
                    push_ev(EV_ON_DN,  cyc + SYNC + 2);
                end
            end else begin
                push_ev(EV_RST_DN, cyc + SYNC + 1);
                push_ev(EV_CLK_DN, cyc + SYNC + 1 + HOLD + 1);
            end
        end
        axi_isolated_i <= ack_new;
    end

    // Output edge monitor.
    logic p_clk = 1'b0, p_rst = 1'b0, p_iso = 1'b1, p_on = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_en_o !== p_clk)      ev_check(clk_en_o      ? EV_CLK_UP : EV_CLK_DN);
            if (domain_rst_no !== p_rst) ev_check(domain_rst_no ? EV_RST_UP : EV_RST_DN);
            if (axi_isolate_o !== p_iso) ev_check(axi_isolate_o ? EV_ISO_UP : EV_ISO_DN);
            if (on_o !== p_on)           ev_check(on_o          ? EV_ON_UP  : EV_ON_DN);
        end
        p_clk <= clk_en_o;
        p_rst <= domain_rst_no;
        p_iso <= axi_isolate_o;
        p_on  <= on_o;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    task automatic power_up(output int t);
        t = cyc;
        en_i = 1'b1;
        push_ev(EV_CLK_UP, t + 1);
        push_ev(EV_RST_UP, t + 1 + SETTLE);
        push_ev(EV_ISO_DN, t + 1 + SETTLE + HOLD);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_clk_en"}, 32'(clk_en_o), 32'd0);
        chk({tag, "_rst_n"},  32'(domain_rst_no), 32'd0);
        chk({tag, "_iso"},    32'(axi_isolate_o), 32'd1);
        chk({tag, "_busy"},   32'(busy_o), 32'd0);
        chk({tag, "_on"},     32'(on_o), 32'd0);
        chk({tag, "_err"},    32'(err_o), 32'd0);
        chk({tag, "_state"},  32'(state_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int u;

        // Reset state
        wait_until(2);
        check_reset_outputs("rst");
        rst_ni = 1'b1;
        wait_until(5);
        chk("idle_state", 32'(state_o), 32'd0);

        // Power-up at cycle 10
        wait_until(10);
        power_up(t);
        wait_until(t + 1);
        chk("clk_on_state", 32'(state_o), 32'd1);
        chk("clk_on_busy", 32'(busy_o), 32'd1);
        wait_until(t + 1 + SETTLE);
        chk("rst_rel_state", 32'(state_o), 32'd2);
        wait_state(3'd4, 100, "pu_reach_on");
        chk("on_busy", 32'(busy_o), 32'd0);
        chk("on_err", 32'(err_o), 32'd0);
        chk("on_all_active", 32'({clk_en_o, domain_rst_no, axi_isolate_o}), 32'b110);

        // Power-down from ON
        wait_until(cyc + 5);
        u = cyc;
        en_i = 1'b0;
        push_ev(EV_ISO_UP, u + 1);
        push_ev(EV_ON_DN,  u + 1);
        wait_until(u + 1);
        chk("iso_state", 32'(state_o), 32'd5);
        wait_state(3'd0, 100, "pd_reach_off");
        chk("pd_busy", 32'(busy_o), 32'd0);
        chk("pd_sb_drained", 32'(sb.size()), 32'd0);

        // en_i dropped during RST_REL: sequence completes, then shuts down
        wait_until(cyc + 5);
        power_up(t);
        wait_until(t + 12);
        chk("toggle_in_rst_rel", 32'(state_o), 32'd2);
        en_i = 1'b0;
        wait_state(3'd0, 200, "toggle_reach_off");
        chk("toggle_sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset while in DEISO
        wait_until(cyc + 5);
        power_up(t);
        wait_state(3'd3, 100, "ar_reach_deiso");
        sb_auto = 1'b0;
        #2;
        mon_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        en_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        wait_until(cyc + 10);
        chk("ar_after_release", 32'(state_o), 32'd0);
        chk("ar_sb_drained", 32'(sb.size()), 32'd0);
        mon_en = 1'b1;
        sb_auto = 1'b1;

        // Clear pulse with no error pending
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("clr_idle_err", 32'(err_o), 32'd0);

`ifdef ETH_DOMAIN_CTRL_TIMEOUT_EN
        // Isolation hang: ack stays low in ISO
        wait_until(cyc + 3);
        power_up(t);
        wait_state(3'd4, 100, "ih_reach_on");
        hang_low = 1'b1;
        wait_until(cyc + 2);
        u = cyc;
        en_i = 1'b0;
        push_ev(EV_ISO_UP, u + 1);
        push_ev(EV_ON_DN,  u + 1);
        push_ev(EV_RST_DN, u + 1 + TMO);
        push_ev(EV_CLK_DN, u + 1 + TMO + HOLD + 1);
        wait_until(u + TMO);
        chk("ih_err_before", 32'(err_o), 32'd0);
        chk("ih_state_before", 32'(state_o), 32'd5);
        wait_until(u + 1 + TMO);
        chk("ih_err_set", 32'(err_o), 32'd1);
        chk("ih_forced_rst", 32'(state_o), 32'd6);
        wait_state(3'd0, 50, "ih_reach_off");
        sb_auto = 1'b0;
        hang_low = 1'b0;
        wait_until(cyc + 8);
        sb_auto = 1'b1;
        chk("ih_err_sticky", 32'(err_o), 32'd1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("ih_err_cleared", 32'(err_o), 32'd0);

        // De-isolation hang: ack stays high in DEISO
        hang_high = 1'b1;
        wait_until(cyc + 3);
        power_up(t);
        push_ev(EV_ISO_UP, t + 1 + SETTLE + HOLD + TMO);
        push_ev(EV_RST_DN, t + 2 + SETTLE + HOLD + TMO);
        push_ev(EV_CLK_DN, t + 2 + SETTLE + HOLD + TMO + HOLD + 1);
        wait_until(t + 100);
        en_i = 1'b0;
        wait_until(t + SETTLE + HOLD + TMO);
        chk("dh_err_before", 32'(err_o), 32'd0);
        chk("dh_state_before", 32'(state_o), 32'd3);
        // Clear coincides with the timeout: the set must win.
        err_clr_i = 1'b1;
        wait_until(t + 1 + SETTLE + HOLD + TMO);
        err_clr_i = 1'b0;
        chk("dh_err_set_wins", 32'(err_o), 32'd1);
        chk("dh_forced_iso", 32'(state_o), 32'd5);
        wait_state(3'd0, 50, "dh_reach_off");
        chk("dh_on_never", 32'(on_o), 32'd0);
        hang_high = 1'b0;
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        chk("dh_err_cleared", 32'(err_o), 32'd0);
`endif

        wait_until(cyc + 5);
        chk("final_sb_drained", 32'(sb.size()), 32'd0);
        chk("final_state", 32'(state_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
